pdm_tx: RTL and testbench



---
 rtl/pdm_tx.sv | 135 +++++++++++++
 tb/tb_pdm_tx.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pdm_tx.sv
// PCM-to-PDM transmitter: sample FIFO, bit-clock divider and a second-order
// sigma-delta modulator producing a 1-bit stream with a companion bit clock.
module pdm_tx #(
    parameter int CLK_DIV    = 8,
    parameter int OSR        = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int IW         = 20
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [15:0]                   pcm_in,
    input  logic                          pcm_valid,
    output logic                          pcm_ready,
    output logic                          pdm_clk,
    output logic                          pdm_out,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int DW = $clog2(CLK_DIV);
    localparam int BW = (OSR > 2) ? $clog2(OSR) : 1;
    localparam int EW = IW + 2;
    localparam logic signed [EW-1:0] SAT_HI = {3'b000, {(IW-1){1'b1}}};
    localparam logic signed [EW-1:0] SAT_LO = {3'b111, {(IW-1){1'b0}}};

    logic [15:0]           mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         count_q, count_d;
    logic [DW-1:0]         div_cnt_q, div_cnt_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                  pdm_clk_q, pdm_clk_d, pdm_out_q, pdm_out_d;
    logic                  underrun_q, underrun_d;
    logic signed [15:0]    hold_q, hold_d, x;
    logic signed [IW-1:0]  i1_q, i1_d, i2_q, i2_d;
    logic signed [EW-1:0]  fb, s1, s2;
    logic                  full, empty, push, pop, tick, boundary;

    function automatic logic signed [IW-1:0] sat(input logic signed [EW-1:0] v);
        if (v > SAT_HI)      return SAT_HI[IW-1:0];
        else if (v < SAT_LO) return SAT_LO[IW-1:0];
        else                 return v[IW-1:0];
    endfunction

    always_comb begin
        full      = (count_q == LW'(FIFO_DEPTH));
        empty     = (count_q == '0);
        push      = pcm_valid && !full;
        tick      = enable && (div_cnt_q == DW'(CLK_DIV - 1));
        boundary  = tick && (bit_cnt_q == BW'(OSR - 1));
        pop       = boundary && !empty;

        wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d   = count_q;
        if (push && !pop)      count_d = count_q + LW'(1);
        else if (pop && !push) count_d = count_q - LW'(1);

        // A boundary tick modulates the freshly loaded sample, not the old hold value.
        x = hold_q;
        if (boundary) x = empty ? '0 : mem_q[rd_ptr_q];

        fb = pdm_out_q ? EW'(32767) : EW'(-32768);
        s1 = EW'(i1_q) + EW'(x) - fb;
        s2 = EW'(i2_q) + EW'(sat(s1)) - fb;

        div_cnt_d  = '0;
        bit_cnt_d  = BW'(OSR - 1);
        pdm_clk_d  = 1'b0;
        pdm_out_d  = 1'b0;
        i1_d       = '0;
        i2_d       = '0;
        hold_d     = '0;
        underrun_d = 1'b0;
        if (enable) begin
            div_cnt_d  = tick ? '0 : div_cnt_q + DW'(1);
            pdm_clk_d  = (div_cnt_d >= DW'(CLK_DIV / 2));
            bit_cnt_d  = bit_cnt_q;
            pdm_out_d  = pdm_out_q;
            i1_d       = i1_q;
            i2_d       = i2_q;
            hold_d     = boundary ? x : hold_q;
            underrun_d = boundary && empty;
            if (tick) begin
                bit_cnt_d = boundary ? '0 : bit_cnt_q + BW'(1);
                i1_d      = sat(s1);
                i2_d      = sat(s2);
                pdm_out_d = !i2_d[IW-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= pcm_in;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            div_cnt_q  <= '0;
            bit_cnt_q  <= BW'(OSR - 1);
            pdm_clk_q  <= 1'b0;
            pdm_out_q  <= 1'b0;
            underrun_q <= 1'b0;
            hold_q     <= '0;
            i1_q       <= '0;
            i2_q       <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            pdm_clk_q  <= pdm_clk_d;
            pdm_out_q  <= pdm_out_d;
            underrun_q <= underrun_d;
            hold_q     <= hold_d;
            i1_q       <= i1_d;
            i2_q       <= i2_d;
        end
    end

    always_comb begin
        pcm_ready  = !full;
        pdm_clk    = pdm_clk_q;
        pdm_out    = pdm_out_q;
        underrun   = underrun_q;
        fifo_level = count_q;
    end

endmodule

// File: tb/tb_pdm_tx.sv
// Directed bench for pdm_tx: reset, handshake, bit timing, density,
// underrun and saturation recovery at default parameters.
module tb_pdm_tx;
    logic        clk = 1'b0;
    logic        reset, enable, pcm_valid;
    logic [15:0] pcm_in;
    logic        pcm_ready, pdm_clk, pdm_out, underrun;
    logic [2:0]  fifo_level;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    pdm_tx #(.CLK_DIV(8), .OSR(64), .FIFO_DEPTH(4), .IW(20)) dut (
        .clk(clk), .reset(reset), .enable(enable), .pcm_in(pcm_in),
        .pcm_valid(pcm_valid), .pcm_ready(pcm_ready), .pdm_clk(pdm_clk),
        .pdm_out(pdm_out), .underrun(underrun), .fifo_level(fifo_level)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Each call advances n PDM bits; callers keep it aligned so the 8th edge is a bit tick.
    task automatic run_bits(input int n, output int ones);
        ones = 0;
        repeat (n) begin
            repeat (8) tick();
            ones += int'(pdm_out);
        end
    endtask

    task automatic do_reset();
        pcm_valid = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic fill(input logic [15:0] v);
        pcm_in = v;
        pcm_valid = 1'b1;
        repeat (6) tick();
        chk("fill_level", 32'(fifo_level), 4);
    endtask

    initial begin
        int   ones, pulses, violations, early, minv;
        logic prev_clk, prev_out;
        bit   found;
        bit   first_bits[4];
        first_bits = '{1'b1, 1'b1, 1'b0, 1'b1};

        reset = 1'b0; enable = 1'b0; pcm_valid = 1'b0; pcm_in = '0;
        repeat (3) tick();
        chk("reset_pdm_clk", 32'(pdm_clk), 0);
        chk("reset_pdm_out", 32'(pdm_out), 0);
        chk("reset_underrun", 32'(underrun), 0);
        chk("reset_level", 32'(fifo_level), 0);
        reset = 1'b1;
        tick();
        chk("ready_after_reset", 32'(pcm_ready), 1);

        // Handshake with modulator idle: 5 offered, 4 accepted
        pcm_valid = 1'b1; pcm_in = 16'h0000;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("hs_level", 32'(fifo_level), (k < 4) ? k : 4);
            chk("hs_ready", 32'(pcm_ready), (k < 4) ? 1 : 0);
        end

        // Bit clock waveform, first pop at edge 8, first four modulator bits for x=0
        enable = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            tick();
            chk("pdm_clk_wave", 32'(pdm_clk), ((k % 8) >= 4) ? 1 : 0);
            if (k == 7) begin
                chk("no_pop_before_tick", 32'(fifo_level), 4);
                chk("out_before_tick", 32'(pdm_out), 0);
            end
            if (k == 8) chk("first_pop", 32'(fifo_level), 3);
            if (k == 9) chk("refill_after_pop", 32'(fifo_level), 4);
            if (k % 8 == 0) chk("first_bits", 32'(pdm_out), 32'(first_bits[k/8-1]));
        end

        violations = 0; early = 0;
        prev_clk = pdm_clk; prev_out = pdm_out;
        for (int k = 33; k <= 519; k++) begin
            tick();
            if (pdm_out !== prev_out && !(prev_clk === 1'b1 && pdm_clk === 1'b0)) violations++;
            if (fifo_level !== 3'd4) early++;
            prev_clk = pdm_clk; prev_out = pdm_out;
        end
        chk("out_change_off_tick", violations, 0);
        chk("no_early_pop", early, 0);
        tick();
        chk("second_pop_at_520", 32'(fifo_level), 3);
        run_bits(64, ones);
        chk_range("density_zero", ones, 30, 34);

        // Asynchronous reset mid-stream while pdm_clk and pdm_out are high
        found = 1'b0;
        for (int k = 0; k < 64 && !found; k++) begin
            tick();
            if (pdm_clk === 1'b1 && pdm_out === 1'b1) found = 1'b1;
        end
        chk("found_clk_out_high", 32'(found), 1);
        reset = 1'b0;
        #2;
        chk("async_rst_pdm_clk", 32'(pdm_clk), 0);
        chk("async_rst_pdm_out", 32'(pdm_out), 0);
        chk("async_rst_level", 32'(fifo_level), 0);
        chk("async_rst_underrun", 32'(underrun), 0);
        enable = 1'b0; pcm_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("ready_after_async_rst", 32'(pcm_ready), 1);

        fill(16'h4000);
        enable = 1'b1;
        run_bits(64, ones);
        run_bits(256, ones);
        chk_range("density_pos_half", ones, 190, 194);
        enable = 1'b0;
        tick();
        chk("disable_pdm_clk", 32'(pdm_clk), 0);
        chk("disable_pdm_out", 32'(pdm_out), 0);
        chk("disable_keeps_fifo", 32'(fifo_level), 4);
        do_reset();

        fill(16'hC000);
        enable = 1'b1;
        run_bits(64, ones);
        run_bits(256, ones);
        chk_range("density_neg_half", ones, 62, 66);
        enable = 1'b0;
        do_reset();

        // Empty FIFO: underrun every 512 clk, silence modulated
        enable = 1'b1; pulses = 0; ones = 0;
        for (int k = 1; k <= 1543; k++) begin
            tick();
            pulses += int'(underrun);
            if (k == 8) chk("underrun_first", 32'(underrun), 1);
            if (k == 9) chk("underrun_one_cycle", 32'(underrun), 0);
            if (k >= 520 && k < 1032 && k % 8 == 0) ones += int'(pdm_out);
        end
        chk("underrun_pulses", pulses, 3);
        chk_range("density_underrun", ones, 30, 34);
        pcm_in = 16'h1234; pcm_valid = 1'b1;
        tick();
        pcm_valid = 1'b0;
        chk("underrun_on_push_boundary", 32'(underrun), 1);
        chk("push_on_boundary_level", 32'(fifo_level), 1);
        pulses = 0;
        for (int k = 1545; k <= 2055; k++) begin
            tick();
            pulses += int'(underrun);
        end
        chk("no_underrun_between", pulses, 0);
        chk("sample_waits", 32'(fifo_level), 1);
        tick();
        chk("late_sample_popped", 32'(fifo_level), 0);
        chk("late_sample_no_underrun", 32'(underrun), 0);
        enable = 1'b0;
        do_reset();

        // Full-scale input then silence: integrators must clamp, not wrap
        fill(16'h7FFF);
        enable = 1'b1;
        run_bits(64, ones);
        minv = 64;
        for (int w = 1; w < 64; w++) begin
            run_bits(64, ones);
            if (ones < minv) minv = ones;
        end
        chk_range("fullscale_density_min", minv, 62, 64);
        pcm_in = 16'h0000;
        run_bits(384, ones);
        run_bits(64, ones);
        chk_range("recover_density", ones, 30, 34);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
